noc_packet_arbiter: RTL and testbench
=====================================

Name: noc_packet_arbiter

Overview:
- Packet-level round-robin arbiter sharing one NoC link channel (flit/last/valid/ready) among PORTS tile-local requesters, e.g. the message-passing buffer, DMA and debug bridge within a compute tile, ahead of noc_out_flit.
- Holds a grant from the first flit of a packet until its last flit, so packets never interleave on the shared channel.
- Sits between the tile-internal packet sources and one channel of the mesh router input.

Parameters:
- FLIT_WIDTH, 32, flit data width; equals CONFIG.NOC_FLIT_WIDTH.
- PORTS, 3, number of requesters; legal range 2..8.
- PORTS_LOG2, $clog2(PORTS), derived localparam; width of the grant index.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_flit  in  PORTS*FLIT_WIDTH  requester flits; port p occupies bits [(p+1)*FLIT_WIDTH-1 : p*FLIT_WIDTH].
- in_last  in  PORTS  last-flit marker per requester.
- in_valid  in  PORTS  flit valid per requester.
- in_ready  out  PORTS  flit accepted per requester.
- out_flit  out  FLIT_WIDTH  flit to the NoC.
- out_last  out  1  last-flit marker to the NoC.
- out_valid  out  1  flit valid to the NoC.
- out_ready  in  1  NoC accepts the flit.
- grant_idx  out  PORTS_LOG2  currently locked port; status only.
- busy  out  1  high while in LOCKED.

Behaviour:
- Reset: applied asynchronously on rst_n low.
  - Reset values: state=IDLE, rr_ptr=0, grant_idx=0, busy=0.
  - Outputs under reset: out_valid=0, in_ready=0, out_flit=0, out_last=0.
- Transfer rule: a flit transfers on the cycle where out_valid && out_ready.
- State IDLE:
  - Outputs: in_ready=0, out_valid=0.
  - If any in_valid is set: pick the first set bit searching from rr_ptr upward, modulo PORTS.
  - Register the pick into grant_idx and move to LOCKED on the next edge.
  - Arbitration latency is exactly 1 cycle, from in_valid seen in IDLE to out_valid.
- State LOCKED:
  - Combinational path: out_flit/out_last/out_valid = in_*[grant_idx]; in_ready[grant_idx] = out_ready. All other in_ready bits = 0.
  - No registers in the data path; a back-to-back flit stream sustains 1 flit/cycle.
  - On a transfer with out_last=1: go to IDLE and set rr_ptr = (grant_idx+1) mod PORTS. The wrap from PORTS-1 goes to 0.
- Idle gap: each packet costs one IDLE cycle. Inter-packet throughput is therefore (len)/(len+1); this is accepted.
- Requester valid drops mid-packet: the lock is held, out_valid follows in_valid, and no other port is granted.
- Simultaneous requests: resolved purely by rr_ptr order. The port just served gets the lowest priority.
- Single-flit packet (last on first flit): LOCKED for exactly one transfer cycle, then IDLE.
- Reset while LOCKED: the in-flight packet is abandoned and no flit is transferred during reset. The NoC side is reset by the same rst_n.
- out_ready and in_valid are never combinationally fed back to in_valid; no loops.

Optional Feature:
- Macro: OPTIMSOC_NOC_ARB_WATCHDOG_EN.
- With the macro defined:
  - Adds a 16-bit stall counter, cleared on every transfer and on entry to LOCKED.
  - The counter increments each LOCKED cycle that has no transfer.
  - When the counter reaches 16'hFFFF: raise output port watchdog_err (1 bit, sticky until reset), force state to IDLE, and advance rr_ptr past grant_idx.
- Without the macro: no counter and no watchdog_err port; the lock is held indefinitely.

Decomposition:
- Shared package noc_arb_pkg:
  - typedef enum logic {IDLE, LOCKED} noc_arb_state_t.
  - localparam WATCHDOG_LIMIT = 16'hFFFF.
- Sub-module noc_arb_rr: combinational round-robin picker.
  - Inputs: req[PORTS], ptr[PORTS_LOG2].
  - Outputs: gnt_idx, any.
  - Also reusable by a debug-ring or DMA scheduler.

Test Plan:
- Reset and single packet: PORTS=3, rst_n low for 3 cycles, then port1 sends 4 flits 0xA0..0xA3 with last on 0xA3 and out_ready=1.
  - out_valid rises 1 cycle after in_valid[1].
  - Exactly 4 transfers occur, with grant_idx=1.
  - busy falls after the 0xA3 transfer and rr_ptr=2.
- All ports always valid, 2-flit packets: grant order must be 0,1,2,0,1,2.
  - No flit of one port appears between the first and last flit of another.
- Backpressure: port0 sends a 3-flit packet with out_ready toggling 1,0,0,1,1.
  - in_ready[0] mirrors out_ready.
  - Flits are not duplicated or dropped.
  - Port2 requesting meanwhile gets in_ready[2]=0 throughout.
- Wrap-around: after port2 is served, ports 0 and 2 both request; port0 must win.
- Mid-packet valid gap: port1 drops in_valid for 5 cycles between flit 1 and 2 while port0 is valid.
  - The lock stays on 1 and port0 waits.
- Reset mid-packet: assert rst_n low after 2 of 5 flits. With OPTIMSOC_NOC_ARB_WATCHDOG_EN, hold out_ready=0 for 65535 LOCKED cycles.
  - Reset: outputs go to reset values immediately, asynchronously.
  - Watchdog: watchdog_err=1, state IDLE, next grant goes to the next port.

Source files
------------

// File: rtl/noc_arb_pkg.sv
// Shared types and constants for the NoC packet arbiter and its round-robin picker.
// The optional stall watchdog (OPTIMSOC_NOC_ARB_WATCHDOG_EN) uses WATCHDOG_LIMIT.
package noc_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } noc_arb_state_t;

    localparam logic [15:0] WATCHDOG_LIMIT = 16'hFFFF;

endpackage : noc_arb_pkg

// File: rtl/noc_arb_rr.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo PORTS.
// Purely combinational so it can be shared with other schedulers in the tile.
module noc_arb_rr #(
    parameter int PORTS = 3,
    localparam int PORTS_LOG2 = $clog2(PORTS)
) (
    input  logic [PORTS-1:0]      req,
    input  logic [PORTS_LOG2-1:0] ptr,
    output logic [PORTS_LOG2-1:0] gnt_idx,
    output logic                  any
);

    localparam logic [PORTS_LOG2:0] PORTS_W = (PORTS_LOG2 + 1)'(PORTS);

    genvar gi;

    // cand_idx[k] is the port examined k-th, i.e. (ptr + k) mod PORTS.
    logic [PORTS_LOG2-1:0] cand_idx [PORTS];

    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_cand
            logic [PORTS_LOG2:0] sum;
            logic [PORTS_LOG2:0] wrapped;
            assign sum     = {1'b0, ptr} + (PORTS_LOG2 + 1)'(gi);
            assign wrapped = sum - PORTS_W;
            assign cand_idx[gi] = (sum >= PORTS_W) ? wrapped[PORTS_LOG2-1:0]
                                                   : sum[PORTS_LOG2-1:0];
        end
    endgenerate

    // Scan from the furthest candidate down so the nearest requester wins.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (req[cand_idx[i]]) begin
                gnt_idx = cand_idx[i];
                any     = 1'b1;
            end
        end
    end

endmodule : noc_arb_rr

// File: rtl/noc_packet_arbiter.sv
// Packet-level round-robin arbiter sharing one NoC channel; grant held from first to last flit.
// Optional stall watchdog with sticky watchdog_err output: define OPTIMSOC_NOC_ARB_WATCHDOG_EN.
module noc_packet_arbiter #(
    parameter int FLIT_WIDTH = 32,
    parameter int PORTS = 3,
    localparam int PORTS_LOG2 = $clog2(PORTS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PORTS*FLIT_WIDTH-1:0] in_flit,
    input  logic [PORTS-1:0]            in_last,
    input  logic [PORTS-1:0]            in_valid,
    output logic [PORTS-1:0]            in_ready,
    output logic [FLIT_WIDTH-1:0]       out_flit,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PORTS_LOG2-1:0]       grant_idx,
    output logic                        busy
`ifdef OPTIMSOC_NOC_ARB_WATCHDOG_EN
    ,
    output logic                        watchdog_err
`endif
);

    import noc_arb_pkg::*;

    localparam logic [PORTS_LOG2-1:0] LAST_PORT = PORTS_LOG2'(PORTS - 1);

    genvar gi;

    noc_arb_state_t        state_q, state_d;
    logic [PORTS_LOG2-1:0] grant_q, grant_d;
    logic [PORTS_LOG2-1:0] rr_ptr_q, rr_ptr_d;
    logic [PORTS_LOG2-1:0] pick_idx;
    logic [PORTS_LOG2-1:0] ptr_after_grant;
    logic                  pick_any;
    logic                  xfer;
    logic [FLIT_WIDTH-1:0] flit_arr [PORTS];

`ifdef OPTIMSOC_NOC_ARB_WATCHDOG_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] stall_cnt_inc;
    logic        wd_err_q, wd_err_d;
`endif

    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_unpack
            assign flit_arr[gi] = in_flit[gi*FLIT_WIDTH +: FLIT_WIDTH];
        end
    endgenerate

    noc_arb_rr #(
        .PORTS (PORTS)
    ) u_rr (
        .req     (in_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // The port just served drops to lowest priority.
    assign ptr_after_grant = (grant_q == LAST_PORT) ? '0 : grant_q + 1'b1;

    // Data path is a pure mux so a locked stream moves one flit per cycle.
    always_comb begin
        out_flit  = '0;
        out_last  = 1'b0;
        out_valid = 1'b0;
        in_ready  = '0;
        if (state_q == LOCKED) begin
            out_flit           = flit_arr[grant_q];
            out_last           = in_last[grant_q];
            out_valid          = in_valid[grant_q];
            in_ready[grant_q]  = out_ready;
        end
    end

    assign xfer = out_valid && out_ready;

`ifdef OPTIMSOC_NOC_ARB_WATCHDOG_EN
    assign stall_cnt_inc = stall_cnt_q + 16'd1;
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
`ifdef OPTIMSOC_NOC_ARB_WATCHDOG_EN
        stall_cnt_d = stall_cnt_q;
        wd_err_d    = wd_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = LOCKED;
`ifdef OPTIMSOC_NOC_ARB_WATCHDOG_EN
                    stall_cnt_d = '0;
`endif
                end
            end
            LOCKED: begin
                if (xfer && out_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = ptr_after_grant;
                end
`ifdef OPTIMSOC_NOC_ARB_WATCHDOG_EN
                // A stalled lock is broken once the counter would reach the limit.
                if (xfer) begin
                    stall_cnt_d = '0;
                end else if (stall_cnt_inc == WATCHDOG_LIMIT) begin
                    stall_cnt_d = '0;
                    wd_err_d    = 1'b1;
                    state_d     = IDLE;
                    rr_ptr_d    = ptr_after_grant;
                end else begin
                    stall_cnt_d = stall_cnt_inc;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef OPTIMSOC_NOC_ARB_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            wd_err_q    <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            wd_err_q    <= wd_err_d;
        end
    end

    assign watchdog_err = wd_err_q;
`endif

    assign grant_idx = grant_q;
    assign busy      = (state_q == LOCKED);

endmodule : noc_packet_arbiter

// File: tb/tb_noc_packet_arbiter.sv
// Directed bench for noc_packet_arbiter (PORTS=3, FLIT_WIDTH=32); watchdog steps need OPTIMSOC_NOC_ARB_WATCHDOG_EN.
module tb_noc_packet_arbiter;

    localparam int FW = 32;
    localparam int NP = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NP*FW-1:0] in_flit;
    logic [NP-1:0]   in_last;
    logic [NP-1:0]   in_valid;
    logic [NP-1:0]   in_ready;
    logic [FW-1:0]   out_flit;
    logic            out_last;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      grant_idx;
    logic            busy;
`ifdef OPTIMSOC_NOC_ARB_WATCHDOG_EN
    logic            watchdog_err;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0]  port;
        logic        last;
        logic [31:0] flit;
    } xfer_t;

    xfer_t log_q[$];

    noc_packet_arbiter #(
        .FLIT_WIDTH (FW),
        .PORTS      (NP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_flit      (in_flit),
        .in_last      (in_last),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_flit     (out_flit),
        .out_last     (out_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .grant_idx    (grant_idx),
        .busy         (busy)
`ifdef OPTIMSOC_NOC_ARB_WATCHDOG_EN
        ,
        .watchdog_err (watchdog_err)
`endif
    );

    always #5 clk = ~clk;

    // Inputs only change just after posedge, so negedge values are what the next edge transfers.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1)
            log_q.push_back({grant_idx, out_last, out_flit});
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input int p, input logic [31:0] f, input logic l);
        xfer_t e;
        chk({tag, "_avail"}, 64'(log_q.size() != 0), 64'd1);
        if (log_q.size() != 0) begin
            e = log_q.pop_front();
            chk(tag, 64'(e), 64'({2'(p), l, f}));
            $display("xfer %s port=%0d flit=%08h last=%0b", tag, e.port, e.flit, e.last);
        end
    endtask

    task automatic set_flit(input int p, input logic [31:0] v);
        in_flit[p*FW +: FW] = v;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent[NP];
        int pkts[NP];
        int pat[5];
        int guard;
        int idx;
        logic [NP-1:0] acc;

        // ---------------- reset ----------------
        rst_n = 1'b0;
        in_valid = 3'b111;
        in_last = 3'b111;
        in_flit = {32'h33, 32'h22, 32'h11};
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_flit", 64'(out_flit), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant_idx), 64'd0);
        cyc();
        rst_n = 1'b1;
        in_valid = '0;
        in_last = '0;
        in_flit = '0;
        cyc();

        // ---------------- single 4-flit packet on port1 ----------------
        in_valid = 3'b010;
        set_flit(1, 32'hA0);
        @(negedge clk);
        chk("t1_latency_idle_valid", 64'(out_valid), 64'd0);
        chk("t1_latency_idle_ready", 64'(in_ready), 64'd0);
        cyc();
        for (int k = 0; k < 4; k++) begin
            set_flit(1, 32'hA0 + 32'(k));
            in_last[1] = (k == 3);
            @(negedge clk);
            chk("t1_out_valid", 64'(out_valid), 64'd1);
            chk("t1_out_flit", 64'(out_flit), 64'(32'hA0 + 32'(k)));
            chk("t1_grant", 64'(grant_idx), 64'd1);
            chk("t1_in_ready", 64'(in_ready), 64'b010);
            cyc();
        end
        in_valid = '0;
        in_last = '0;
        @(negedge clk);
        chk("t1_busy_after_last", 64'(busy), 64'd0);
        for (int k = 0; k < 4; k++) pop_chk("t1", 1, 32'hA0 + 32'(k), k == 3);
        chk("t1_log_empty", 64'(log_q.size()), 64'd0);
        cyc();

        // ---------------- rr_ptr=2, wrap to port0, single-flit packets ----------------
        in_valid = 3'b101;
        in_last = 3'b101;
        set_flit(0, 32'hB0);
        set_flit(2, 32'hB2);
        @(negedge clk);
        chk("t2_idle_busy", 64'(busy), 64'd0);
        cyc();
        @(negedge clk);
        chk("t2_ptr2_grant", 64'(grant_idx), 64'd2);
        cyc();
        set_flit(2, 32'hB3);
        @(negedge clk);
        chk("t2_single_flit_idle", 64'(busy), 64'd0);
        cyc();
        @(negedge clk);
        chk("t2_wrap_grant0", 64'(grant_idx), 64'd0);
        cyc();
        in_valid = 3'b100;
        @(negedge clk);
        cyc();
        @(negedge clk);
        chk("t2_then_grant2", 64'(grant_idx), 64'd2);
        cyc();
        in_valid = '0;
        in_last = '0;
        pop_chk("t2a", 2, 32'hB2, 1'b1);
        pop_chk("t2b", 0, 32'hB0, 1'b1);
        pop_chk("t2c", 2, 32'hB3, 1'b1);
        chk("t2_log_empty", 64'(log_q.size()), 64'd0);

        // ---------------- all ports valid, 2-flit packets, 2 packets each ----------------
        for (int p = 0; p < NP; p++) begin
            sent[p] = 0;
            pkts[p] = 0;
        end
        guard = 0;
        while ((pkts[0] < 2 || pkts[1] < 2 || pkts[2] < 2) && guard < 60) begin
            for (int p = 0; p < NP; p++) begin
                in_valid[p] = (pkts[p] < 2);
                set_flit(p, 32'h5000_0000 + 32'(p * 256 + pkts[p] * 16 + sent[p]));
                in_last[p] = (sent[p] == 1);
            end
            @(negedge clk);
            acc = in_ready & in_valid;
            cyc();
            for (int p = 0; p < NP; p++) begin
                if (acc[p]) begin
                    sent[p]++;
                    if (sent[p] == 2) begin
                        sent[p] = 0;
                        pkts[p]++;
                    end
                end
            end
            guard++;
        end
        in_valid = '0;
        in_last = '0;
        chk("t3_cycles", 64'(guard), 64'd18);
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < NP; p++)
                for (int f = 0; f < 2; f++)
                    pop_chk("t3", p, 32'h5000_0000 + 32'(p * 256 + k * 16 + f), f == 1);
        chk("t3_log_empty", 64'(log_q.size()), 64'd0);

        // ---------------- backpressure on port0, port2 waiting ----------------
        in_valid = 3'b101;
        set_flit(0, 32'hC0);
        set_flit(2, 32'hD0);
        in_last = 3'b100;
        @(negedge clk);
        chk("t4_idle_valid", 64'(out_valid), 64'd0);
        cyc();
        pat = '{1, 0, 0, 1, 1};
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            out_ready = pat[i][0];
            set_flit(0, 32'hC0 + 32'(idx));
            in_last[0] = (idx == 2);
            @(negedge clk);
            chk("t4_ready0_mirror", 64'(in_ready[0]), 64'(pat[i][0]));
            chk("t4_ready2_low", 64'(in_ready[2]), 64'd0);
            chk("t4_flit", 64'(out_flit), 64'(32'hC0 + 32'(idx)));
            cyc();
            if (pat[i] != 0) idx++;
        end
        in_valid[0] = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_idle_after", 64'(busy), 64'd0);
        cyc();
        @(negedge clk);
        chk("t4_port2_grant", 64'(grant_idx), 64'd2);
        cyc();
        in_valid = '0;
        in_last = '0;
        for (int k = 0; k < 3; k++) pop_chk("t4", 0, 32'hC0 + 32'(k), k == 2);
        pop_chk("t4_d0", 2, 32'hD0, 1'b1);
        chk("t4_log_empty", 64'(log_q.size()), 64'd0);

        // ---------------- mid-packet valid gap on port1 ----------------
        in_valid = 3'b010;
        set_flit(1, 32'hE0);
        in_last = '0;
        cyc();
        @(negedge clk);
        chk("t5_grant1", 64'(grant_idx), 64'd1);
        cyc();
        set_flit(1, 32'hE1);
        cyc();
        in_valid = 3'b001;
        set_flit(0, 32'hF0);
        in_last = 3'b001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_gap_valid", 64'(out_valid), 64'd0);
            chk("t5_gap_lock", 64'({busy, grant_idx}), 64'b101);
            chk("t5_gap_ready", 64'(in_ready), 64'b010);
            cyc();
        end
        in_valid = 3'b011;
        set_flit(1, 32'hE2);
        in_last = 3'b011;
        @(negedge clk);
        chk("t5_resume_flit", 64'(out_flit), 64'hE2);
        cyc();
        in_valid = 3'b001;
        cyc();
        @(negedge clk);
        chk("t5_port0_grant", 64'(grant_idx), 64'd0);
        cyc();
        in_valid = '0;
        in_last = '0;
        for (int k = 0; k < 3; k++) pop_chk("t5", 1, 32'hE0 + 32'(k), k == 2);
        pop_chk("t5_f0", 0, 32'hF0, 1'b1);
        chk("t5_log_empty", 64'(log_q.size()), 64'd0);

        // ---------------- reset mid-packet ----------------
        in_valid = 3'b010;
        set_flit(1, 32'h60);
        cyc();
        cyc();
        set_flit(1, 32'h61);
        cyc();
        set_flit(1, 32'h62);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 64'(out_valid), 64'd0);
        chk("t6_async_ready", 64'(in_ready), 64'd0);
        chk("t6_async_busy", 64'(busy), 64'd0);
        chk("t6_async_grant", 64'(grant_idx), 64'd0);
        chk("t6_async_flit", 64'({out_last, out_flit}), 64'd0);
        cyc();
        in_valid = '0;
        cyc();
        rst_n = 1'b1;
        pop_chk("t6_g0", 1, 32'h60, 1'b0);
        pop_chk("t6_g1", 1, 32'h61, 1'b0);
        chk("t6_log_empty", 64'(log_q.size()), 64'd0);
        in_valid = 3'b101;
        in_last = 3'b101;
        set_flit(0, 32'h70);
        set_flit(2, 32'h72);
        cyc();
        @(negedge clk);
        chk("t6_ptr_reset_grant", 64'(grant_idx), 64'd0);
        cyc();
        in_valid = 3'b100;
        cyc();
        cyc();
        in_valid = '0;
        in_last = '0;
        pop_chk("t6_h0", 0, 32'h70, 1'b1);
        pop_chk("t6_h2", 2, 32'h72, 1'b1);

`ifdef OPTIMSOC_NOC_ARB_WATCHDOG_EN
        // ---------------- watchdog ----------------
        in_valid = 3'b110;
        in_last = 3'b100;
        set_flit(1, 32'h81);
        set_flit(2, 32'h82);
        out_ready = 1'b0;
        @(negedge clk);
        chk("t7_err_init", 64'(watchdog_err), 64'd0);
        cyc();
        repeat (65534) cyc();
        @(negedge clk);
        chk("t7_still_locked", 64'({busy, grant_idx, watchdog_err}), 64'b1010);
        cyc();
        out_ready = 1'b1;
        @(negedge clk);
        chk("t7_timeout", 64'({busy, watchdog_err}), 64'b01);
        cyc();
        @(negedge clk);
        chk("t7_next_grant", 64'(grant_idx), 64'd2);
        cyc();
        in_valid = '0;
        in_last = '0;
        @(negedge clk);
        chk("t7_err_sticky", 64'(watchdog_err), 64'd1);
        pop_chk("t7_j2", 2, 32'h82, 1'b1);
        chk("t7_log_empty", 64'(log_q.size()), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_noc_packet_arbiter
